// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern-detection controller.
// Holds a pattern configuration, sequences a detection run over a gated
// serial bit stream, raises a Mealy match pulse, counts matches and ends
// the run once a programmed match target has been reached.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_we,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         x_valid,
    input  logic                         x,
    output logic                         busy,
    output logic                         z,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   pattern_q, pattern_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 overlap_q, overlap_d;
    logic [CNT_W-1:0]     target_q, target_d;
    logic [MAX_LEN-2:0]   hist_q, hist_d;
    logic [LEN_W-1:0]     fill_q, fill_d;
    logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0]   window;
    logic [MAX_LEN-1:0]   len_mask;
    logic [LEN_W-1:0]     len_m1;
    logic [LEN_W-1:0]     fill_next;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 len_legal;
    logic                 pattern_hit;
    logic                 match;

    // The newest bit joins the stored history to form the comparison window.
    assign window      = {hist_q, x};
    assign len_m1      = len_q - LEN_W'(1);
    assign len_legal   = (len_q >= LEN_W'(2)) && (len_q <= LEN_W'(MAX_LEN));
    assign fill_next   = (fill_q == len_m1) ? fill_q : fill_q + LEN_W'(1);
    assign cnt_inc     = (match_cnt_q == {CNT_W{1'b1}}) ? match_cnt_q : match_cnt_q + CNT_W'(1);
    assign pattern_hit = (fill_q == len_m1) && (((window ^ pattern_q) & len_mask) == '0);

    // Mask selecting only the low len_q bits of the window and pattern.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Next-state, register-update and match logic for the run controller.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        overlap_d   = overlap_q;
        target_d    = target_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_cnt_d = match_cnt_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        match       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_legal) begin
                        state_d     = ST_RUN;
                        hist_d      = '0;
                        fill_d      = '0;
                        match_cnt_d = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    overlap_d = cfg_overlap;
                    target_d  = cfg_target;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (x_valid) begin
                    hist_d = window[MAX_LEN-2:0];
                    if (pattern_hit) begin
                        match       = 1'b1;
                        match_cnt_d = cnt_inc;
                        fill_d      = overlap_q ? fill_next : '0;
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        fill_d = fill_next;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = !abort;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            target_q    <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            overlap_q   <= overlap_d;
            target_q    <= target_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign z         = match && !reset;
    assign match_cnt = match_cnt_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: self-checking bench for seq_det_ctrl. A behavioural model
// keeps the received bits in a queue and matches the tail against the pattern.
module tb_seq_det_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               x_valid;
    logic               x;
    logic               busy;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               done;
    logic               cfg_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    int                 m_tgt;
    bit                 m_running;
    bit                 m_wrap;
    bit                 m_done;
    bit                 m_err;
    int                 m_cnt;
    bit                 m_seen[$];

    always #5 clk = ~clk;

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .abort(abort), .x_valid(x_valid), .x(x),
        .busy(busy), .z(z), .match_cnt(match_cnt), .done(done), .cfg_err(cfg_err)
    );

    function automatic void model_reset();
        m_pat = '0; m_len = 0; m_ovl = 0; m_tgt = 0;
        m_running = 0; m_wrap = 0; m_done = 0; m_err = 0; m_cnt = 0;
        m_seen.delete();
    endfunction

    // True when the last m_len received bits spell the pattern, oldest first.
    function automatic bit tail_matches();
        if (m_seen.size() != m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_seen[i] != m_pat[m_len-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance the model by one clock; returns the expected z for this cycle.
    function automatic bit model_step(bit we, bit st, bit ab, bit xv, bit xb);
        bit zexp     = 1'b0;
        bit nxt_done = 1'b0;
        bit nxt_err  = 1'b0;
        if (m_wrap) begin
            m_wrap   = 1'b0;
            nxt_done = !ab;
        end else if (m_running) begin
            if (ab) begin
                m_running = 1'b0;
            end else if (xv) begin
                m_seen.push_back(xb);
                if (m_seen.size() > m_len) void'(m_seen.pop_front());
                if (tail_matches()) begin
                    zexp = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (!m_ovl) m_seen.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) begin
                        m_running = 1'b0;
                        m_wrap    = 1'b1;
                    end
                end
            end
        end else begin
            if (st) begin
                if (m_len >= 2 && m_len <= MAX_LEN) begin
                    m_running = 1'b1;
                    m_cnt     = 0;
                    m_seen.delete();
                end else begin
                    nxt_err = 1'b1;
                end
            end
            if (we) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                m_tgt = int'(cfg_target);
            end
        end
        m_done = nxt_done;
        m_err  = nxt_err;
        return zexp;
    endfunction

    // Drive one cycle of control inputs, sample z mid-cycle, step the model.
    task automatic tick_cycle(input bit we, input bit st, input bit ab, input bit xv,
                              input bit xb, output logic z_obs, output bit z_exp);
        cfg_we = we; start = st; abort = ab; x_valid = xv; x = xb;
        #2;
        z_obs = z;
        z_exp = model_step(we, st, ab, xv, xb);
        @(posedge clk);
        #1;
        cfg_we = 0; start = 0; abort = 0; x_valid = 0; x = 0;
    endtask

    task automatic configure(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl,
                             input int tgt);
        logic zo;
        bit   ze;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_target  = CNT_W'(tgt);
        tick_cycle(1, 0, 0, 0, 0, zo, ze);
    endtask

    task automatic do_reset();
        reset = 1; cfg_we = 0; start = 0; abort = 0; x_valid = 0; x = 0;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        cfg_pattern = '1; cfg_len = '1; cfg_overlap = 1; cfg_target = '1;
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (z !== 1'b0) begin failures++; $display("[TB] FAIL reset_z got=%b exp=0", z); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        checks++; if (match_cnt !== '0) begin failures++; $display("[TB] FAIL reset_match_cnt got=%0d exp=0", match_cnt); end
    endtask

    task automatic test_overlap(input bit ovl);
        logic       zo;
        bit         ze;
        logic [6:0] zvec;
        bit         s[7] = '{1, 0, 1, 0, 1, 0, 1};
        logic [6:0] zreq = ovl ? 7'b1010000 : 7'b0010000;
        configure(8'b0001_0101, 5, ovl, 0);
        tick_cycle(0, 1, 0, 0, 0, zo, ze);
        for (int i = 0; i < 7; i++) begin
            tick_cycle(0, 0, 0, 1, s[i], zo, ze);
            zvec[i] = zo;
            checks++; if (zo !== ze) begin failures++; $display("[TB] FAIL ovl%0d_z bit%0d got=%b exp=%b", ovl, i+1, zo, ze); end
            checks++; if (match_cnt !== CNT_W'(m_cnt)) begin failures++; $display("[TB] FAIL ovl%0d_cnt bit%0d got=%0d exp=%0d", ovl, i+1, match_cnt, m_cnt); end
        end
        checks++; if (zvec !== zreq) begin failures++; $display("[TB] FAIL ovl%0d_zpos got=%b exp=%b", ovl, zvec, zreq); end
        checks++; if (match_cnt !== (ovl ? 8'd2 : 8'd1)) begin failures++; $display("[TB] FAIL ovl%0d_final_cnt got=%0d exp=%0d", ovl, match_cnt, ovl ? 2 : 1); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ovl%0d_busy got=%b exp=1", ovl, busy); end
        do_reset();
    endtask

    task automatic test_target();
        logic zo;
        bit   ze;
        bit   s[7] = '{1, 0, 1, 0, 1, 0, 1};
        configure(8'b0001_0101, 5, 1, 2);
        tick_cycle(0, 1, 0, 0, 0, zo, ze);
        for (int i = 0; i < 7; i++) begin
            tick_cycle(0, 0, 0, 1, s[i], zo, ze);
            checks++; if (zo !== ze) begin failures++; $display("[TB] FAIL target_z bit%0d got=%b exp=%b", i+1, zo, ze); end
            checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL target_early_done bit%0d got=%b exp=0", i+1, done); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL target_busy_after got=%b exp=0", busy); end
        checks++; if (match_cnt !== 8'd2) begin failures++; $display("[TB] FAIL target_cnt got=%0d exp=2", match_cnt); end
        tick_cycle(0, 0, 0, 1, 1, zo, ze);
        checks++; if (zo !== 1'b0) begin failures++; $display("[TB] FAIL target_ignored_bit_z got=%b exp=0", zo); end
        checks++; if (done !== 1'b1 || m_done !== 1'b1) begin failures++; $display("[TB] FAIL target_done_pulse got=%b exp=1", done); end
        checks++; if (match_cnt !== 8'd2) begin failures++; $display("[TB] FAIL target_cnt_hold got=%0d exp=2", match_cnt); end
        tick_cycle(0, 0, 0, 0, 0, zo, ze);
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL target_done_width got=%b exp=0", done); end
        checks++; if (busy !== 1'b0 || match_cnt !== 8'd2) begin failures++; $display("[TB] FAIL target_idle_hold busy=%b cnt=%0d exp busy=0 cnt=2", busy, match_cnt); end
        tick_cycle(0, 1, 0, 0, 0, zo, ze);
        checks++; if (match_cnt !== 8'd0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL target_restart busy=%b cnt=%0d exp busy=1 cnt=0", busy, match_cnt); end
        do_reset();
    endtask

    task automatic test_illegal_len();
        logic zo;
        bit   ze;
        int   lens[4] = '{1, 0, 9, 15};
        bit   s[5]    = '{1, 0, 1, 0, 1};
        foreach (lens[k]) begin
            configure(8'b0000_0001, lens[k], 0, 0);
            tick_cycle(0, 1, 0, 0, 0, zo, ze);
            checks++; if (cfg_err !== 1'b1 || m_err !== 1'b1) begin failures++; $display("[TB] FAIL illegal_len%0d_err got=%b exp=1", lens[k], cfg_err); end
            checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal_len%0d_busy got=%b exp=0", lens[k], busy); end
            tick_cycle(0, 0, 0, 1, 1, zo, ze);
            checks++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal_len%0d_after err=%b busy=%b exp 0 0", lens[k], cfg_err, busy); end
        end
        configure(8'b0001_0101, 5, 1, 0);
        tick_cycle(0, 1, 0, 0, 0, zo, ze);
        cfg_pattern = 8'b0000_0010; cfg_len = LEN_W'(2); cfg_overlap = 0; cfg_target = 8'd1;
        tick_cycle(1, 0, 0, 0, 0, zo, ze);
        for (int i = 0; i < 5; i++) begin
            tick_cycle(0, 0, 0, 1, s[i], zo, ze);
            checks++; if (zo !== ((i == 4) ? 1'b1 : 1'b0)) begin failures++; $display("[TB] FAIL run_cfg_we_z bit%0d got=%b exp=%b", i+1, zo, (i == 4)); end
        end
        checks++; if (busy !== 1'b1 || match_cnt !== 8'd1) begin failures++; $display("[TB] FAIL run_cfg_we_state busy=%b cnt=%0d exp busy=1 cnt=1", busy, match_cnt); end
        do_reset();
    endtask

    task automatic test_gaps();
        logic zo;
        bit   ze;
        int   hits = 0;
        bit   s[5] = '{1, 0, 1, 0, 1};
        configure(8'b0001_0101, 5, 1, 0);
        tick_cycle(0, 1, 0, 0, 0, zo, ze);
        for (int i = 0; i < 5; i++) begin
            tick_cycle(0, 0, 0, 1, s[i], zo, ze);
            if (zo === 1'b1) hits++;
            checks++; if (zo !== ((i == 4) ? 1'b1 : 1'b0)) begin failures++; $display("[TB] FAIL gap_z bit%0d got=%b exp=%b", i+1, zo, (i == 4)); end
            if (i < 4) begin
                for (int g = 0; g < 3; g++) begin
                    tick_cycle(0, 0, 0, 0, ~s[i], zo, ze);
                    if (zo === 1'b1) hits++;
                end
            end
        end
        checks++; if (hits != 1) begin failures++; $display("[TB] FAIL gap_hits got=%0d exp=1", hits); end
        checks++; if (match_cnt !== 8'd1) begin failures++; $display("[TB] FAIL gap_cnt got=%0d exp=1", match_cnt); end
        do_reset();
    endtask

    task automatic test_abort();
        logic zo;
        bit   ze;
        bit   s[5] = '{1, 0, 1, 0, 1};
        configure(8'b0001_0101, 5, 1, 1);
        tick_cycle(0, 1, 0, 0, 0, zo, ze);
        for (int i = 0; i < 4; i++) tick_cycle(0, 0, 0, 1, s[i], zo, ze);
        tick_cycle(0, 0, 1, 1, s[4], zo, ze);
        checks++; if (zo !== 1'b0 || ze !== 1'b0) begin failures++; $display("[TB] FAIL abort_z got=%b exp=0", zo); end
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("[TB] FAIL abort_cnt got=%0d exp=0", match_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
        for (int i = 0; i < 2; i++) begin
            tick_cycle(0, 0, 0, 1, 1, zo, ze);
            checks++; if (done !== 1'b0 || zo !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_done cyc%0d done=%b z=%b exp 0 0", i, done, zo); end
        end
        do_reset();
    endtask

    task automatic test_reset_midrun();
        logic zo;
        bit   ze;
        bit   s[5] = '{1, 0, 1, 0, 1};
        configure(8'b0001_0101, 5, 1, 0);
        tick_cycle(0, 1, 0, 0, 0, zo, ze);
        for (int i = 0; i < 5; i++) tick_cycle(0, 0, 0, 1, s[i], zo, ze);
        reset = 1; x_valid = 1; x = 0;
        @(posedge clk);
        #1;
        reset = 0; x_valid = 0;
        model_reset();
        checks++; if (busy !== 0 || done !== 0 || cfg_err !== 0 || match_cnt !== '0 || z !== 0) begin
            failures++; $display("[TB] FAIL midrun_reset busy=%b done=%b err=%b cnt=%0d z=%b exp all 0", busy, done, cfg_err, match_cnt, z);
        end
        tick_cycle(0, 0, 0, 1, 1, zo, ze);
        checks++; if (busy !== 0 || done !== 0 || cfg_err !== 0 || zo !== 0) begin failures++; $display("[TB] FAIL midrun_reset_after busy=%b done=%b err=%b z=%b", busy, done, cfg_err, zo); end
    endtask

    task automatic test_saturate();
        logic zo;
        bit   ze;
        configure(8'b0000_0011, 2, 1, 0);
        tick_cycle(0, 1, 0, 0, 0, zo, ze);
        for (int i = 0; i < 300; i++) begin
            tick_cycle(0, 0, 0, 1, 1, zo, ze);
            if (match_cnt !== CNT_W'(m_cnt)) begin checks++; failures++; $display("[TB] FAIL sat_cnt bit%0d got=%0d exp=%0d", i, match_cnt, m_cnt); end
        end
        checks++; if (match_cnt !== 8'hFF) begin failures++; $display("[TB] FAIL sat_final got=%0d exp=255", match_cnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL sat_busy got=%b exp=1", busy); end
        do_reset();
    endtask

    task automatic test_random();
        logic               zo;
        bit                 ze;
        int                 len;
        int                 ptr;
        bit                 xb;
        bit                 xv;
        logic [MAX_LEN-1:0] pat;
        for (int run = 0; run < 25; run++) begin
            len = $urandom_range(2, MAX_LEN);
            pat = MAX_LEN'($urandom);
            configure(pat, len, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
            ptr = 0;
            for (int c = 0; c < 60; c++) begin
                xv = ($urandom_range(0, 3) != 0);
                xb = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1)) : pat[len-1-ptr];
                if (xv) ptr = (ptr + 1) % len;
                if (($urandom_range(0, 9) == 0)) begin
                    cfg_pattern = MAX_LEN'($urandom);
                    cfg_len     = LEN_W'($urandom_range(0, 15));
                    cfg_target  = CNT_W'($urandom_range(0, 3));
                    cfg_overlap = 1'($urandom_range(0, 1));
                end
                tick_cycle(1'($urandom_range(0, 9) == 0), (c == 0) || ($urandom_range(0, 29) == 0),
                           ($urandom_range(0, 79) == 0), xv, xb, zo, ze);
                checks++; if (zo !== ze) begin failures++; $display("[TB] FAIL rand_z run%0d cyc%0d got=%b exp=%b", run, c, zo, ze); end
                checks++; if (match_cnt !== CNT_W'(m_cnt)) begin failures++; $display("[TB] FAIL rand_cnt run%0d cyc%0d got=%0d exp=%0d", run, c, match_cnt, m_cnt); end
                checks++; if (busy !== m_running) begin failures++; $display("[TB] FAIL rand_busy run%0d cyc%0d got=%b exp=%b", run, c, busy, m_running); end
                checks++; if (done !== m_done) begin failures++; $display("[TB] FAIL rand_done run%0d cyc%0d got=%b exp=%b", run, c, done, m_done); end
                checks++; if (cfg_err !== m_err) begin failures++; $display("[TB] FAIL rand_cfg_err run%0d cyc%0d got=%b exp=%b", run, c, cfg_err, m_err); end
            end
            tick_cycle(0, 0, 1, 0, 0, zo, ze);
            tick_cycle(0, 0, 1, 0, 0, zo, ze);
            checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rand_end_busy run%0d got=%b exp=0", run, busy); end
        end
    endtask

    initial begin
        cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_target = '0;
        start = 0; abort = 0; x_valid = 0; x = 0; reset = 1;
        model_reset();
        test_reset();
        test_overlap(1'b1);
        test_overlap(1'b0);
        test_target();
        test_illegal_len();
        test_gaps();
        test_abort();
        test_reset_midrun();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern-detection controller. It holds the pattern configuration, sequences a detection run over a gated serial bit stream, and raises a Mealy match pulse. It counts matches and terminates the run at a programmed match target. It sits between a host/config interface and a serial input source, and replaces per-pattern hard-coded detector FSMs.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cfg_we  input  1  config write strobe (honoured in IDLE only)
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is first bit received, bit [0] is last
cfg_len  input  $clog2(MAX_LEN+1)  pattern length in bits
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = restart after each match
cfg_target  input  CNT_W  stop after this many matches; 0 = free-run
start  input  1  begin a run (IDLE only)
abort  input  1  terminate the run immediately
x_valid  input  1  x is a valid stream bit this cycle
x  input  1  serial data bit
busy  output  1  high in RUN
z  output  1  Mealy match pulse, combinational from x in the matching cycle
match_cnt  output  CNT_W  matches in current/last run
done  output  1  one-cycle pulse when the target is reached
cfg_err  output  1  one-cycle pulse on start with an illegal length

Behaviour:
- Clocking and reset: clk only. Reset is synchronous and active-high. Reset forces state to IDLE and clears every output and internal register: busy=0, done=0, cfg_err=0, match_cnt=0, z=0, pattern/len/overlap/target regs=0, history=0, fill=0.
- Config registers: when cfg_we=1 in IDLE, the regs load cfg_* on the next edge. cfg_we is ignored in RUN and DONE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with len_reg<2 or len_reg>MAX_LEN: cfg_err=1 on the next cycle for exactly 1 cycle; state stays IDLE.
  - start=1 with a legal length: go to RUN. history=0, fill=0, match_cnt=0.
  - cfg_we and start in the same cycle: start uses the old register values.
- RUN:
  - busy=1.
  - On x_valid=1: history <= {history[MAX_LEN-3:0], x}. fill <= min(fill+1, len_reg-1).
  - Match condition: x_valid and fill==len_reg-1 and low len_reg bits of {history, x} equal pattern_reg[len_reg-1:0].
  - z=match, combinational in the same cycle as the completing bit.
  - On match: match_cnt increments, saturating at all-ones. If cfg_overlap=0, fill is cleared to 0 instead of incrementing.
  - x_valid=0: no shift, z=0, state held. Gaps are transparent to matching.
  - Target reached: target_reg!=0 and the match brings match_cnt to target_reg → next state DONE. Bits after that cycle are ignored.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. match_cnt holds until the next legal start.
- abort=1 in RUN or DONE:
  - Highest priority: z forced 0, no count update, next state IDLE, no done pulse.
  - abort in IDLE has no effect.
- Latency: z has zero latency from the completing bit. match_cnt updates 1 cycle later. done follows 2 cycles after the target-reaching bit.
- start while in RUN or DONE is ignored.
- Reset mid-run: returns to IDLE with all state cleared. No done and no cfg_err pulse is issued.

Test Plan:
1. pattern=5'b10101, len=5, overlap=1, target=0; stream 1,0,1,0,1,0,1 with x_valid=1 → z high on bits 5 and 7; match_cnt=2; busy stays 1.
2. Same stream with overlap=0 → z only on bit 5; match_cnt=1.
3. overlap=1, target=2, same stream → z on bit 7; done pulses 2 cycles after bit 7; busy=0 afterwards; match_cnt holds 2; a new start clears it to 0.
4. Illegal length: len=1 then start → cfg_err single-cycle pulse; state IDLE; busy=0. len=0 gives the same result. cfg_we during RUN does not change the pattern.
5. Gapped stream: bits 1,0,1,0,1 with x_valid=0 for 3 cycles between each → z only on the final valid bit; z=0 during gaps.
6. Abort and reset:
   - abort asserted in the same cycle as the completing 5th bit → z=0, match_cnt unchanged, IDLE, no done.
   - reset mid-run → all outputs 0 on the next cycle.
